// File: rtl/rr_grant_ctrl_pkg.sv
// Shared definitions for the rr_grant_ctrl round-robin arbiter: requester count,
// state encoding and the combinational round-robin search helper.
package rr_grant_ctrl_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set request at or after ptr, searching upward and wrapping 7 -> 0.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                      input logic [IDX_W-1:0] ptr);
        pick_t            res;
        logic [IDX_W-1:0] cand;
        logic             take;
        res.found = 1'b0;
        res.idx   = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            cand      = ptr + IDX_W'(i);
            take      = !res.found && req[cand];
            res.idx   = take ? cand : res.idx;
            res.found = res.found | take;
        end
        return res;
    endfunction

    // Pointer position that makes idx the lowest priority next round.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/rr_grant_ctrl_decoder.sv
// decoder_3to8: one-hot decode of the granted index, forced to zero when en is low.
module decoder_3to8
    import rr_grant_ctrl_pkg::*;
(
    input  logic [IDX_W-1:0] x,
    input  logic             en,
    output logic [N_REQ-1:0] D
);

    // One-hot decode gated by en
    always_comb begin
        D = {N_REQ{1'b0}};
        if (en) begin
            D[x] = 1'b1;
        end else begin
            D = {N_REQ{1'b0}};
        end
    end

endmodule

// File: rtl/rr_grant_ctrl.sv
// rr_grant_ctrl: 8-requester round-robin grant controller (IDLE -> GRANT -> GAP).
// Optional forced release after HOLD_MAX grant cycles when RR_TIMEOUT_EN is defined.
module rr_grant_ctrl
    import rr_grant_ctrl_pkg::*;
#(
    parameter int HOLD_MAX = 15
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             timeout
);

    if (HOLD_MAX < 1) begin : g_hold_chk
        $error("rr_grant_ctrl: HOLD_MAX must be at least 1");
    end

    state_t           state_r;
    state_t           state_nxt_s;
    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] ptr_nxt_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_nxt_s;
    pick_t            pick_s;
    logic             grant_s;

`ifdef RR_TIMEOUT_EN
    localparam int             CW       = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0]  HOLD_LIM = CW'(HOLD_MAX);
    localparam logic [CW-1:0]  HOLD_ONE = CW'(1);

    logic [CW-1:0] hold_cnt_r;
    logic          hold_clr_s;
    logic          hold_inc_s;
    logic          hold_expire_s;
    logic          timeout_r;
    logic          timeout_nxt_s;

    assign hold_expire_s = ((hold_cnt_r + HOLD_ONE) == HOLD_LIM);
`endif

    assign pick_s = rr_pick(req, ptr_r);

    // Next-state, pointer and grant-index selection
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        idx_nxt_s   = idx_r;
`ifdef RR_TIMEOUT_EN
        hold_clr_s    = 1'b0;
        hold_inc_s    = 1'b0;
        timeout_nxt_s = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (en && pick_s.found) begin
                    state_nxt_s = ST_GRANT;
                    idx_nxt_s   = pick_s.idx;
`ifdef RR_TIMEOUT_EN
                    hold_clr_s  = 1'b1;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!en) begin
                    state_nxt_s = ST_IDLE;
                end else if (!req[idx_r]) begin
                    state_nxt_s = ST_GAP;
                    ptr_nxt_s   = next_ptr(idx_r);
`ifdef RR_TIMEOUT_EN
                end else if (hold_expire_s) begin
                    state_nxt_s   = ST_GAP;
                    ptr_nxt_s     = next_ptr(idx_r);
                    timeout_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_GRANT;
                    hold_inc_s  = 1'b1;
                end
`else
                end else begin
                    state_nxt_s = ST_GRANT;
                end
`endif
            end
            ST_GAP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // All controller state, including the optional hold counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ptr_r   <= {IDX_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
`ifdef RR_TIMEOUT_EN
            hold_cnt_r <= {CW{1'b0}};
            timeout_r  <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            idx_r   <= idx_nxt_s;
`ifdef RR_TIMEOUT_EN
            timeout_r <= timeout_nxt_s;
            if (hold_clr_s) begin
                hold_cnt_r <= {CW{1'b0}};
            end else if (hold_inc_s) begin
                hold_cnt_r <= hold_cnt_r + HOLD_ONE;
            end else begin
                hold_cnt_r <= hold_cnt_r;
            end
`endif
        end
    end

    assign grant_s = (state_r == ST_GRANT);
    assign gnt_vld = grant_s;
    assign gnt_idx = idx_r;

`ifdef RR_TIMEOUT_EN
    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif

    // gnt is only ever non-zero while in GRANT, so reset clears it immediately
    decoder_3to8 u_dec (
        .x  (idx_r),
        .en (grant_s),
        .D  (gnt)
    );

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Scoreboard bench for rr_grant_ctrl: directed scenarios plus random traffic,
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_rr_grant_ctrl;

    localparam int HOLD = 4;
    localparam int PH_IDLE = 0;
    localparam int PH_BUSY = 1;
    localparam int PH_GAP  = 2;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
        logic       to;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    int   n_vec;
    int   n_bad;
    exp_t exp_q[$];

    int   m_phase;
    int   m_ptr;
    int   m_who;
    int   m_held;
    bit   m_to;

    rr_grant_ctrl #(.HOLD_MAX(HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_ptr   = 0;
        m_who   = 0;
        m_held  = 0;
        m_to    = 1'b0;
    endtask

    // Reference: one rising edge worth of the arbitration rules
    task automatic model_step();
        bit found;
        int k;
        found = 1'b0;
        m_to  = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (m_phase == PH_IDLE) begin
            if (en) begin
                for (int j = 0; j < 8; j++) begin
                    k = (m_ptr + j) % 8;
                    if (!found && req[k]) begin
                        found = 1'b1;
                        m_who = k;
                    end
                end
                if (found) begin
                    m_phase = PH_BUSY;
                    m_held  = 1;
                end
            end
        end else if (m_phase == PH_BUSY) begin
            if (!en) begin
                m_phase = PH_IDLE;
            end else if (!req[m_who]) begin
                m_phase = PH_GAP;
                m_ptr   = (m_who + 1) % 8;
`ifdef RR_TIMEOUT_EN
            end else if (m_held == HOLD) begin
                m_phase = PH_GAP;
                m_ptr   = (m_who + 1) % 8;
                m_to    = 1'b1;
`endif
            end else begin
                m_held++;
            end
        end else begin
            m_phase = PH_IDLE;
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.vld = (m_phase == PH_BUSY);
        e.gnt = e.vld ? (8'h01 << m_who) : 8'h00;
        e.idx = 3'(m_who);
        e.to  = m_to;
        exp_q.push_back(e);
    endtask

    // Apply inputs for one clock, advance the model, return at negedge + 1
    task automatic cycle(input logic [7:0] r, input logic e);
        req = r;
        en  = e;
        @(posedge clk);
        model_step();
        push_expected();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        cycle(8'h00, 1'b1);
        rst_n = 1'b1;
    endtask

    // Monitor: compare DUT outputs with the scoreboard away from the active edge
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_gnt", 32'(gnt), 32'(e.gnt));
            check("sb_vld", 32'(gnt_vld), 32'(e.vld));
            check("sb_timeout", 32'(timeout), 32'(e.to));
            if (e.vld) begin
                check("sb_idx", 32'(gnt_idx), 32'(e.idx));
            end
        end
    end

    initial begin
        logic [7:0] r;
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 8'h00;
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_idx", 32'(gnt_idx), 32'h0);
        check("rst_vld", 32'(gnt_vld), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        model_reset();
        cycle(8'h00, 1'b0);
        rst_n = 1'b1;

        // en low blocks grants
        cycle(8'h10, 1'b0);
        check("en_low_gnt", 32'(gnt), 32'h0);
        cycle(8'h10, 1'b0);
        check("en_low_gnt2", 32'(gnt), 32'h0);

        // single request, then pointer moves past it
        cycle(8'h04, 1'b1);
        check("single_gnt", 32'(gnt), 32'h04);
        check("single_idx", 32'(gnt_idx), 32'd2);
        cycle(8'h00, 1'b1);
        check("single_gap", 32'(gnt), 32'h0);
        cycle(8'h00, 1'b1);
        cycle(8'h0C, 1'b1);
        check("ptr_after_2", 32'(gnt_idx), 32'd3);
        cycle(8'h00, 1'b1);
        cycle(8'h00, 1'b1);

        // wrap-around 7 -> 0
        cycle(8'h40, 1'b1);
        check("wrap_pre6", 32'(gnt_idx), 32'd6);
        cycle(8'h00, 1'b1);
        cycle(8'h00, 1'b1);
        cycle(8'h81, 1'b1);
        check("wrap_7", 32'(gnt_idx), 32'd7);
        cycle(8'h01, 1'b1);
        cycle(8'h01, 1'b1);
        cycle(8'h01, 1'b1);
        check("wrap_0", 32'(gnt), 32'h01);
        cycle(8'h00, 1'b1);
        cycle(8'h00, 1'b1);

        // en dropped mid-grant keeps the pointer
        cycle(8'h10, 1'b1);
        check("en_grant4", 32'(gnt_idx), 32'd4);
        cycle(8'h10, 1'b0);
        check("en_revoke", 32'(gnt), 32'h0);
        cycle(8'h11, 1'b1);
        check("en_ptr_kept", 32'(gnt_idx), 32'd4);

        // asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_gnt", 32'(gnt), 32'h0);
        check("arst_vld", 32'(gnt_vld), 32'h0);
        model_reset();
        cycle(8'h06, 1'b1);
        rst_n = 1'b1;
        cycle(8'h06, 1'b1);
        check("arst_regrant", 32'(gnt), 32'h02);
        cycle(8'h00, 1'b1);
        cycle(8'h00, 1'b1);

        // fairness: all requesting, each served for two cycles
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            cycle(8'hFF, 1'b1);
            check("fair_order", 32'(gnt_idx), 32'(k % 8));
            cycle(8'hFF, 1'b1);
            cycle(8'hFF & ~(8'h01 << (k % 8)), 1'b1);
            cycle(8'hFF, 1'b1);
        end

`ifdef RR_TIMEOUT_EN
        // forced release after HOLD grant cycles
        apply_reset();
        cycle(8'h03, 1'b1);
        check("to_first", 32'(gnt_idx), 32'd0);
        for (int k = 0; k < HOLD - 1; k++) begin
            cycle(8'h03, 1'b1);
            check("to_hold", 32'(gnt), 32'h01);
        end
        cycle(8'h03, 1'b1);
        check("to_pulse", 32'(timeout), 32'h1);
        check("to_gap", 32'(gnt), 32'h0);
        cycle(8'h03, 1'b1);
        check("to_pulse_end", 32'(timeout), 32'h0);
        cycle(8'h03, 1'b1);
        check("to_next", 32'(gnt), 32'h02);
`endif

        // random traffic: requesters hold until served, en occasionally low
        apply_reset();
        r = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 8; i++) begin
                if (r[i]) begin
                    if (m_phase == PH_BUSY && m_who == i && $urandom_range(3) == 0) begin
                        r[i] = 1'b0;
                    end
                end else if ($urandom_range(3) == 0) begin
                    r[i] = 1'b1;
                end
            end
            cycle(r, ($urandom_range(15) != 0) ? 1'b1 : 1'b0);
        end

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
